// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1-to-L2 line-port arbiter: FSM states, grant source, tie-break helper.
package cache_arbiter_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_LINE_W = 256;

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP_I,
        RESP_D
    } arb_state_t;

    typedef enum logic {
        ARB_I,
        ARB_D
    } arb_src_t;

    // Single requesters always win; ties go to D unless round-robin flips away from last_grant.
    function automatic arb_src_t arb_pick(input logic i_req, input logic d_req,
                                          input arb_src_t last_grant, input logic rr_en);
        arb_src_t win;
        if (i_req && d_req) begin
            if (rr_en)
                win = (last_grant == ARB_I) ? ARB_D : ARB_I;
            else
                win = ARB_D;
        end else begin
            win = d_req ? ARB_D : ARB_I;
        end
        return win;
    endfunction

endpackage

// File: rtl/arb_line_buffer.sv
// Line-wide load-enable register, cleared by rst.
// Latency: 1 cycle from ld to q. No backpressure: loads whenever ld is high.
module arb_line_buffer #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (ld)
            q <= d;
    end

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache reads and D-cache reads/write-backs onto one L2 line port, one miss at a time.
// Latency: grant +1 cycle to mem_*, resp one cycle after mem_resp. Requests are held by the caches
// until resp; the memory request is held until mem_resp. CACHE_ARB_RR_EN selects round-robin ties.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

`ifdef CACHE_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    arb_state_t        state_q, state_d;
    arb_src_t          last_grant_q;
    arb_src_t          grant;
    logic              op_wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] line_q;
    logic              d_req;
    logic              take;
    logic              line_ld;
    logic              wdata_ld;
    logic              serving;

    assign d_req    = d_read | d_write;
    assign grant    = arb_pick(i_read, d_req, last_grant_q, RR_EN);
    assign wdata_ld = take && (grant == ARB_D) && d_write;

    always_comb begin
        state_d   = state_q;
        take      = 1'b0;
        line_ld   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_read || d_req) begin
                    take    = 1'b1;
                    state_d = (grant == ARB_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    line_ld = 1'b1;
                    state_d = RESP_I;
                end
            end
            SERVE_D: begin
                mem_read  = ~op_wr_q;
                mem_write = op_wr_q;
                if (mem_resp) begin
                    line_ld = 1'b1;
                    state_d = RESP_D;
                end
            end
            RESP_I: begin
                i_resp  = 1'b1;
                state_d = IDLE;
            end
            RESP_D: begin
                d_resp  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ARB_I;
            op_wr_q      <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                addr_q  <= (grant == ARB_D) ? d_address : i_address;
                op_wr_q <= (grant == ARB_D) && d_write;
            end
            if (state_q == RESP_I)
                last_grant_q <= ARB_I;
            else if (state_q == RESP_D)
                last_grant_q <= ARB_D;
        end
    end

    arb_line_buffer #(.W(LINE_W)) u_wdata_buf (
        .clk (clk),
        .rst (rst),
        .ld  (wdata_ld),
        .d   (d_wdata),
        .q   (wdata_q)
    );

    arb_line_buffer #(.W(LINE_W)) u_resp_buf (
        .clk (clk),
        .rst (rst),
        .ld  (line_ld),
        .d   (mem_rdata),
        .q   (line_q)
    );

    // Downstream address/data are zero outside a transaction; the write line only on a write.
    assign serving     = (state_q == SERVE_I) || (state_q == SERVE_D);
    assign mem_address = serving ? addr_q : '0;
    assign mem_wdata   = (serving && op_wr_q) ? wdata_q : '0;

    assign i_rdata = line_q;
    assign d_rdata = line_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: transaction-level model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_cache_arbiter;

`ifdef CACHE_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read, d_read, d_write, mem_resp;
    logic [31:0]  i_address, d_address;
    logic [255:0] d_wdata, mem_rdata;
    logic [255:0] i_rdata, d_rdata, mem_wdata;
    logic         i_resp, d_resp, mem_read, mem_write;
    logic [31:0]  mem_address;

    cache_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Model: a transaction is either in flight (busy), awaiting its resp pulse, or absent.
    bit           m_busy, m_wr, m_own, m_resp, m_rown, m_last;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata, m_line;

    function automatic bit pick_d(input bit irq, input bit drq, input bit last);
        if (irq && drq) return RR ? (last == 1'b0) : 1'b1;
        return drq;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_resp <= 0; m_last <= 0; m_wr <= 0;
            m_addr <= '0; m_wdata <= '0; m_line <= '0;
        end else if (m_resp) begin
            m_last <= m_rown;
            m_resp <= 0;
        end else if (m_busy) begin
            if (mem_resp) begin
                m_line <= mem_rdata;
                m_busy <= 0;
                m_resp <= 1;
                m_rown <= m_own;
            end
        end else if (i_read || d_read || d_write) begin
            m_busy <= 1;
            m_own  <= pick_d(i_read, d_read || d_write, m_last);
            m_wr   <= pick_d(i_read, d_read || d_write, m_last) && d_write;
            m_addr <= pick_d(i_read, d_read || d_write, m_last) ? d_address : i_address;
            if (pick_d(i_read, d_read || d_write, m_last) && d_write) m_wdata <= d_wdata;
        end
    end

    bit  chk_en = 0;
    int  i_cnt, d_cnt, i_cyc, mem_start;
    bit  prev_act;
    logic [255:0] i_dat;
    bit  order[$];

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("mem_read", mem_read, m_busy && !m_wr);
                chk("mem_write", mem_write, m_busy && m_wr);
                chk("mem_address", mem_address, m_busy ? m_addr : 32'd0);
                chk("mem_wdata", mem_wdata, (m_busy && m_wr) ? m_wdata : 256'd0);
                chk("i_resp", i_resp, m_resp && !m_rown);
                chk("d_resp", d_resp, m_resp && m_rown);
                chk("i_rdata", i_rdata, m_line);
                chk("d_rdata", d_rdata, m_line);
                if (i_resp) begin i_cnt++; i_cyc = cyc; i_dat = i_rdata; order.push_back(1'b0); end
                if (d_resp) begin d_cnt++; order.push_back(1'b1); end
                if ((mem_read || mem_write) && !prev_act) mem_start = cyc;
                prev_act = mem_read || mem_write;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
        @(posedge clk); #1;
        rst = 0;
        i_cnt = 0; d_cnt = 0; order.delete();
    endtask

    task automatic wait_mem(input string name);
        bit seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = mem_read || mem_write;
        end
        if (!seen) chk({name, "_mem_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic pulse_resp(input int lat, input logic [255:0] data);
        repeat (lat) @(posedge clk);
        #1; mem_resp = 1; mem_rdata = data;
        @(posedge clk); #1; mem_resp = 0;
    endtask

    // which: 0 = I, 1 = D, 2 = either
    task automatic wait_resp(input int which, input string name);
        bit seen = 0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = (which != 1 && i_resp) || (which != 0 && d_resp);
        end
        if (!seen) chk({name, "_resp_timeout"}, 1'b0, 1'b1);
    endtask

    int mark, dsave;
    logic [255:0] a5_line, beef_line, f00d_line;

    initial begin
        a5_line   = {32{8'hA5}};
        beef_line = {8{32'hDEADBEEF}};
        f00d_line = {8{32'h0BADF00D}};
        rst = 1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
        i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1; rst = 0; chk_en = 1;
        @(negedge clk);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_i_rdata", i_rdata, 256'd0);
        chk("rst_mem_address", mem_address, 32'd0);

        // 1: I-only read, mem_resp 4 cycles after mem_read
        @(posedge clk); #1;
        i_read = 1; i_address = 32'h0000_0040; mark = cyc;
        wait_mem("t1");
        chk("t1_mem_addr", mem_address, 32'h40);
        pulse_resp(4, a5_line);
        wait_resp(0, "t1");
        @(posedge clk); #1; i_read = 0;
        chk("t1_mem_start_cycle", 256'(mem_start - mark), 256'd1);
        chk("t1_resp_cycle", 256'(i_cyc - mark), 256'd6);
        chk("t1_i_rdata", i_dat, a5_line);
        chk("t1_i_cnt", 256'(i_cnt), 256'd1);
        chk("t1_no_d_resp", 256'(d_cnt), 256'd0);

        // 2: D write-back, requester address/data change mid-transaction
        d_write = 1; d_address = 32'h0000_1000; d_wdata = beef_line;
        wait_mem("t2");
        chk("t2_mem_write", mem_write, 1'b1);
        @(posedge clk); #1;
        d_address = 32'h0000_2000; d_wdata = '0;
        @(negedge clk);
        chk("t2_mem_addr_latched", mem_address, 32'h1000);
        chk("t2_mem_wdata_latched", mem_wdata, beef_line);
        pulse_resp(2, '0);
        wait_resp(1, "t2");
        @(posedge clk); #1; d_write = 0;
        chk("t2_d_cnt", 256'(d_cnt), 256'd1);

        // read and write together: write-back first, refill next
        d_read = 1; d_write = 1; d_address = 32'h0000_3000; d_wdata = f00d_line;
        wait_mem("wb");
        chk("wb_first", {mem_write, mem_read}, 2'b10);
        pulse_resp(1, '0);
        wait_resp(1, "wb");
        @(posedge clk); #1; d_write = 0;
        wait_mem("refill");
        chk("refill_next", {mem_write, mem_read}, 2'b01);
        pulse_resp(1, {16{16'h1234}});
        wait_resp(1, "refill");
        @(posedge clk); #1; d_read = 0;
        chk("refill_d_rdata", d_rdata, {16{16'h1234}});

        // 3: tie from reset, requesters drop after their resp -> D then I
        do_reset();
        i_read = 1; i_address = 32'h100; d_read = 1; d_address = 32'h200;
        wait_mem("t3a");
        chk("t3_first_addr", mem_address, 32'h200);
        pulse_resp(2, {8{32'h11111111}});
        wait_resp(1, "t3a");
        @(posedge clk); #1; d_read = 0;
        wait_mem("t3b");
        pulse_resp(2, {8{32'h22222222}});
        wait_resp(0, "t3b");
        @(posedge clk); #1; i_read = 0;
        chk("t3_count", 256'(order.size()), 256'd2);
        if (order.size() == 2) begin
            chk("t3_order0", order[0], 1'b1);
            chk("t3_order1", order[1], 1'b0);
        end

        // 4: three back-to-back ties from reset with both requests held
        do_reset();
        i_read = 1; d_read = 1;
        for (int t = 0; t < 3; t++) begin
            wait_mem("t4");
            pulse_resp(1, 256'(t + 1));
            wait_resp(2, "t4");
        end
        @(posedge clk); #1; i_read = 0; d_read = 0;
        chk("t4_count", 256'(order.size()), 256'd3);
        if (order.size() == 3) begin
            chk("t4_order0", order[0], 1'b1);
            chk("t4_order1", order[1], RR ? 1'b0 : 1'b1);
            chk("t4_order2", order[2], 1'b1);
        end

        // 5: reset while serving a D read
        do_reset();
        d_read = 1; d_address = 32'h5000;
        wait_mem("t5");
        chk("t5_mem_read_up", mem_read, 1'b1);
        dsave = d_cnt;
        @(posedge clk); #1; rst = 1; d_read = 0;
        @(posedge clk); #1; rst = 0;
        @(negedge clk);
        chk("t5_mem_read_dropped", mem_read, 1'b0);
        chk("t5_d_rdata_cleared", d_rdata, 256'd0);
        repeat (4) @(negedge clk);
        chk("t5_no_d_resp", 256'(d_cnt), 256'(dsave));
        @(posedge clk); #1; i_read = 1; i_address = 32'h6000;
        wait_mem("t5i");
        pulse_resp(3, f00d_line);
        wait_resp(0, "t5i");
        @(posedge clk); #1; i_read = 0;
        chk("t5_i_rdata", i_dat, f00d_line);

        // 6: spurious mem_resp while idle
        dsave = i_cnt + d_cnt;
        repeat (2) @(posedge clk);
        #1; mem_resp = 1; mem_rdata = '1;
        @(posedge clk); #1; mem_resp = 0;
        repeat (3) @(negedge clk);
        chk("t6_i_rdata_kept", i_rdata, f00d_line);
        chk("t6_no_resp", 256'(i_cnt + d_cnt), 256'(dsave));
        chk("t6_mem_idle", {mem_read, mem_write}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
